mobo_master: RTL and testbench

- Parametrised bus-master engine between the CPU core FSM and the motherboard controller.
- Replaces the open-coded CTRL_WRITE/CTRL_READ handshake states with one reusable block.
- Accepts single or burst read/fill-write requests and runs the mobo_ctrl/mobo_stat handshake per beat with auto-incrementing address.
- Returns read data per beat, and reports completion or timeout error.

---
 rtl/mobo_master_pkg.sv | 23 ++
 rtl/mobo_master_if.sv | 40 ++++
 rtl/mobo_timeout_ctr.sv | 39 +++
 rtl/mobo_master.sv | 163 ++++++++++++++++
 tb/tb_mobo_master.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mobo_master_pkg.sv
// Shared encodings for the motherboard handshake and the bus-master FSM.
package mobo_master_pkg;

    localparam int unsigned WORD_WIDTH_DEF = 8;
    localparam int unsigned BURST_W_DEF    = 4;

    // mobo_ctrl command words
    localparam int unsigned CTRL_NONE  = 0;
    localparam int unsigned CTRL_READ  = 1;
    localparam int unsigned CTRL_WRITE = 2;

    // mobo_stat status words
    localparam int unsigned STAT_IDLE = 0;
    localparam int unsigned STAT_BUSY = 1;
    localparam int unsigned STAT_DONE = 2;

    // master FSM encodings
    localparam int unsigned STATE_W     = 2;
    localparam logic [1:0]  S_IDLE      = 2'd0;
    localparam logic [1:0]  S_WAIT_IDLE = 2'd1;
    localparam logic [1:0]  S_WAIT_DONE = 2'd2;

endpackage

// File: rtl/mobo_master_if.sv
// Request/response and motherboard bus bundle for mobo_master.
interface mobo_master_if #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned BURST_W    = 4
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [WORD_WIDTH-1:0] req_addr;
    logic [WORD_WIDTH-1:0] req_data;
    logic [BURST_W-1:0]    req_len;

    logic                  rsp_valid;
    logic [WORD_WIDTH-1:0] rsp_data;
    logic                  rsp_last;
    logic                  rsp_err;
    logic                  busy;

    logic [WORD_WIDTH-1:0] mobo_ctrl;
    logic [WORD_WIDTH-1:0] mobo_stat;
    logic [WORD_WIDTH-1:0] addr_out;
    logic [WORD_WIDTH-1:0] mobodat_out;
    logic [WORD_WIDTH-1:0] mobodat_in;

    modport master (
        input  req_valid, req_write, req_addr, req_data, req_len,
        input  mobo_stat, mobodat_in,
        output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err, busy,
        output mobo_ctrl, addr_out, mobodat_out
    );

    modport slave (
        output req_valid, req_write, req_addr, req_data, req_len,
        output mobo_stat, mobodat_in,
        input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err, busy,
        input  mobo_ctrl, addr_out, mobodat_out
    );

endinterface

// File: rtl/mobo_timeout_ctr.sv
// Wait-state watchdog: expired flags the last allowed cycle; TIMEOUT=0 disables it.
module mobo_timeout_ctr #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // next count: clear wins, otherwise count while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mobo_master.sv
// Bus-master engine: runs the mobo_ctrl/mobo_stat handshake per beat for
// single or burst reads and fill-writes, with per-wait timeout abort.
module mobo_master
    import mobo_master_pkg::*;
#(
    parameter int unsigned WORD_WIDTH  = WORD_WIDTH_DEF,
    parameter int unsigned BURST_W     = BURST_W_DEF,
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned ADDR_STRIDE = 1
) (
    input  logic          clk,
    input  logic          rst,
    mobo_master_if.master bus
);

    localparam logic [WORD_WIDTH-1:0] C_NONE  = WORD_WIDTH'(CTRL_NONE);
    localparam logic [WORD_WIDTH-1:0] C_READ  = WORD_WIDTH'(CTRL_READ);
    localparam logic [WORD_WIDTH-1:0] C_WRITE = WORD_WIDTH'(CTRL_WRITE);
    localparam logic [WORD_WIDTH-1:0] ST_IDLE = WORD_WIDTH'(STAT_IDLE);
    localparam logic [WORD_WIDTH-1:0] ST_DONE = WORD_WIDTH'(STAT_DONE);
    localparam logic [WORD_WIDTH-1:0] STRIDE  = WORD_WIDTH'(ADDR_STRIDE);

    logic [STATE_W-1:0]    state_q,     state_d;
    logic [WORD_WIDTH-1:0] ctrl_q,      ctrl_d;
    logic [WORD_WIDTH-1:0] addr_q,      addr_d;
    logic [WORD_WIDTH-1:0] wdat_q,      wdat_d;
    logic                  write_q,     write_d;
    logic [BURST_W-1:0]    left_q,      left_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [WORD_WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic                  rsp_last_q,  rsp_last_d;
    logic                  rsp_err_q,   rsp_err_d;

    logic tmo_clear_c;
    logic tmo_en_c;
    logic tmo_expired;

    // watchdog restarts on every state entry and runs only in wait states
    assign tmo_clear_c = (state_q == S_IDLE) || (state_d != state_q);
    assign tmo_en_c    = (state_q != S_IDLE);

    mobo_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear_c),
        .enable  (tmo_en_c),
        .expired (tmo_expired)
    );

    // next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        addr_d      = addr_q;
        wdat_d      = wdat_q;
        write_d     = write_q;
        left_d      = left_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = 1'b0;
        rsp_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    wdat_d  = bus.req_data;
                    addr_d  = bus.req_addr;
                    left_d  = bus.req_len;
                    state_d = S_WAIT_IDLE;
                end
            end

            S_WAIT_IDLE: begin
                if (bus.mobo_stat == ST_IDLE) begin
                    ctrl_d  = write_q ? C_WRITE : C_READ;
                    state_d = S_WAIT_DONE;
                end else if (tmo_expired) begin
                    ctrl_d      = C_NONE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_last_d  = 1'b1;
                    rsp_data_d  = '0;
                    state_d     = S_IDLE;
                end
            end

            S_WAIT_DONE: begin
                if (bus.mobo_stat == ST_DONE) begin
                    ctrl_d = C_NONE;
                    if (!write_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = bus.mobodat_in;
                        rsp_last_d  = (left_q == '0);
                    end else if (left_q == '0) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_last_d  = 1'b1;
                    end
                    if (left_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        left_d  = left_q - BURST_W'(1);
                        addr_d  = addr_q + STRIDE;
                        state_d = S_WAIT_IDLE;
                    end
                end else if (tmo_expired) begin
                    ctrl_d      = C_NONE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_last_d  = 1'b1;
                    rsp_data_d  = '0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                ctrl_d  = C_NONE;
                state_d = S_IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ctrl_q      <= C_NONE;
            addr_q      <= '0;
            wdat_q      <= '0;
            write_q     <= 1'b0;
            left_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            addr_q      <= addr_d;
            wdat_q      <= wdat_d;
            write_q     <= write_d;
            left_q      <= left_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready   = (state_q == S_IDLE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.mobo_ctrl   = ctrl_q;
    assign bus.addr_out    = addr_q;
    assign bus.mobodat_out = wdat_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_last    = rsp_last_q;
    assign bus.rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_mobo_master.sv
// Scoreboard bench for mobo_master with a small behavioural motherboard model.
module tb_mobo_master;
    import mobo_master_pkg::*;

    localparam int unsigned WW = 8;
    localparam int unsigned BW = 4;

    typedef struct packed {
        logic [WW-1:0] data;
        logic          last;
        logic          err;
    } rsp_t;

    typedef struct packed {
        logic [WW-1:0] ctrl;
        logic [WW-1:0] addr;
        logic [WW-1:0] wdat;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mobo_master_if #(.WORD_WIDTH(WW), .BURST_W(BW)) bus();

    mobo_master #(
        .WORD_WIDTH  (WW),
        .BURST_W     (BW),
        .TIMEOUT     (8),
        .ADDR_STRIDE (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int rsp_cyc = 0;

    rsp_t  exp_rsp[$];
    beat_t exp_beat[$];

    // motherboard model knobs
    int   m_delay = 3;
    logic m_mode  = 1'b0;   // 0: data 0x5A, 1: data = addr_out + 1
    logic m_hang  = 1'b0;   // hold STAT_BUSY forever
    int   m_cnt   = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // motherboard model: BUSY for m_delay-1 cycles after a command, then DONE
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mobo_stat  <= WW'(STAT_IDLE);
            bus.mobodat_in <= '0;
            m_cnt          <= 0;
        end else if (bus.mobo_ctrl != WW'(CTRL_NONE)) begin
            if (m_hang) begin
                bus.mobo_stat <= WW'(STAT_BUSY);
            end else if (m_cnt == m_delay - 1) begin
                bus.mobo_stat  <= WW'(STAT_DONE);
                bus.mobodat_in <= m_mode ? (bus.addr_out + 8'd1) : 8'h5A;
                m_cnt          <= 0;
            end else begin
                bus.mobo_stat <= WW'(STAT_BUSY);
                m_cnt         <= m_cnt + 1;
            end
        end else begin
            bus.mobo_stat <= WW'(STAT_IDLE);
            m_cnt         <= 0;
        end
    end

    // monitor: pops expectations on each command phase start and each response
    logic [WW-1:0] prev_ctrl = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mobo_ctrl != WW'(CTRL_NONE) && prev_ctrl == WW'(CTRL_NONE)) begin
                rise_cyc = cyc;
                if (exp_beat.size() == 0) begin
                    chk("unexpected_beat", 32'(bus.addr_out), 32'hFFFF_FFFF);
                end else begin
                    beat_t b;
                    b = exp_beat.pop_front();
                    chk("beat_ctrl", 32'(bus.mobo_ctrl), 32'(b.ctrl));
                    chk("beat_addr", 32'(bus.addr_out), 32'(b.addr));
                    chk("beat_wdat", 32'(bus.mobodat_out), 32'(b.wdat));
                end
            end
            if (bus.rsp_valid) begin
                rsp_cyc = cyc;
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", 32'(bus.rsp_data), 32'hFFFF_FFFF);
                end else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    chk("rsp_data", 32'(bus.rsp_data), 32'(r.data));
                    chk("rsp_last", 32'(bus.rsp_last), 32'(r.last));
                    chk("rsp_err",  32'(bus.rsp_err),  32'(r.err));
                    chk("rsp_ctrl_none", 32'(bus.mobo_ctrl), CTRL_NONE);
                end
            end
        end
        prev_ctrl = bus.mobo_ctrl;
    end

    task automatic push_beat(int unsigned ctrl, logic [WW-1:0] addr, logic [WW-1:0] wdat);
        beat_t b;
        b.ctrl = WW'(ctrl);
        b.addr = addr;
        b.wdat = wdat;
        exp_beat.push_back(b);
    endtask

    task automatic push_rsp(logic [WW-1:0] data, logic last, logic err);
        rsp_t r;
        r.data = data;
        r.last = last;
        r.err  = err;
        exp_rsp.push_back(r);
    endtask

    task automatic send(logic wr, logic [WW-1:0] addr, logic [WW-1:0] data, logic [BW-1:0] len);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_len   = len;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(string nm);
        int i;
        for (i = 0; i < 300; i++) begin
            if (exp_rsp.size() == 0 && exp_beat.size() == 0) break;
            @(negedge clk);
        end
        if (exp_rsp.size() != 0 || exp_beat.size() != 0) begin
            chk({nm, "_timeout"}, 32'(exp_rsp.size() + exp_beat.size()), 32'd0);
            exp_rsp.delete();
            exp_beat.delete();
        end
        @(negedge clk);
        chk({nm, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_len   = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl",      32'(bus.mobo_ctrl),   CTRL_NONE);
        chk("rst_addr",      32'(bus.addr_out),    32'd0);
        chk("rst_wdat",      32'(bus.mobodat_out), 32'd0);
        chk("rst_rsp_data",  32'(bus.rsp_data),    32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid),   32'd0);
        chk("rst_busy",      32'(bus.busy),        32'd0);
        chk("rst_ready",     32'(bus.req_ready),   32'd1);
        rst = 1'b0;
        @(negedge clk);

        // single read
        m_mode = 1'b0;
        push_beat(CTRL_READ, 8'h10, 8'h00);
        push_rsp(8'h5A, 1'b1, 1'b0);
        send(1'b0, 8'h10, 8'h00, 4'd0);
        wait_done("single_read");

        // read burst, with an ignored request while busy
        m_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_beat(CTRL_READ, 8'(8'h20 + i), 8'h00);
            push_rsp(8'(8'h21 + i), (i == 3), 1'b0);
        end
        send(1'b0, 8'h20, 8'h00, 4'd3);
        repeat (3) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'hEE;
        bus.req_len   = 4'd5;
        chk("busy_ready", 32'(bus.req_ready), 32'd0);
        chk("busy_busy",  32'(bus.busy),      32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_done("read_burst");

        // fill write
        for (int i = 0; i < 3; i++) push_beat(CTRL_WRITE, 8'(8'h30 + i), 8'h77);
        push_rsp(8'h00, 1'b1, 1'b0);
        send(1'b1, 8'h30, 8'h77, 4'd2);
        wait_done("fill_write");

        // address wrap
        push_beat(CTRL_READ, 8'hFF, 8'h00);
        push_beat(CTRL_READ, 8'h00, 8'h00);
        push_rsp(8'h00, 1'b0, 1'b0);
        push_rsp(8'h01, 1'b1, 1'b0);
        send(1'b0, 8'hFF, 8'h00, 4'd1);
        wait_done("wrap");

        // timeout with the model stuck busy
        m_hang = 1'b1;
        push_beat(CTRL_READ, 8'h40, 8'h00);
        push_rsp(8'h00, 1'b1, 1'b1);
        send(1'b0, 8'h40, 8'h00, 4'd0);
        wait_done("timeout");
        chk("timeout_latency", 32'(rsp_cyc - rise_cyc), 32'd8);
        m_hang = 1'b0;
        m_mode = 1'b0;
        push_beat(CTRL_READ, 8'h70, 8'h00);
        push_rsp(8'h5A, 1'b1, 1'b0);
        send(1'b0, 8'h70, 8'h00, 4'd0);
        wait_done("after_timeout");

        // async reset during beat 2 of a 4-beat burst
        m_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_beat(CTRL_READ, 8'(8'h50 + i), 8'h00);
            push_rsp(8'(8'h51 + i), (i == 3), 1'b0);
        end
        send(1'b0, 8'h50, 8'h00, 4'd3);
        for (int i = 0; i < 100; i++) begin
            if (exp_beat.size() <= 2) break;
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        chk("pre_rst_ctrl", 32'(bus.mobo_ctrl), CTRL_READ);
        rst = 1'b1;
        #1;
        chk("arst_ctrl",  32'(bus.mobo_ctrl), CTRL_NONE);
        chk("arst_busy",  32'(bus.busy),      32'd0);
        chk("arst_addr",  32'(bus.addr_out),  32'd0);
        chk("arst_valid", 32'(bus.rsp_valid), 32'd0);
        exp_beat.delete();
        exp_rsp.delete();
        @(negedge clk);
        chk("arst_hold_valid", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push_beat(CTRL_READ, 8'h60, 8'h00);
        push_rsp(8'h61, 1'b1, 1'b0);
        send(1'b0, 8'h60, 8'h00, 4'd0);
        wait_done("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
